// File: rtl/rom_load_sequencer_if.sv
// rtl/rom_load_sequencer_if.sv - ioctl download stream in, ROM region write port out
// Purpose: bundles the HPS ioctl byte stream and the region write port of the ROM loader.
// Ports (signals):
//   dl_active  download in progress        dl_wr     one-cycle byte strobe
//   dl_addr    byte address (ADDR_W)       dl_data   byte data
//   rom_addr   region-relative offset      rom_data  byte to write
//   rom_we     one-hot region write strobe (4)
// Modports: master drives the download and observes the ROM port, slave is the sequencer.
interface rom_load_sequencer_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              dl_active;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [3:0]        rom_we;

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    input  rom_addr, rom_data, rom_we
  );

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    output rom_addr, rom_data, rom_we
  );
endinterface

// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - galaga ROM download sequencer and core reset gate
// Purpose: decodes ioctl bytes into four ROM region write strobes, checks that the
// image arrives contiguously and complete, and holds the core in reset until a good
// image plus a settle window has passed.
// Ports:
//   clk_sys     system clock, rising edge
//   reset_n     asynchronous active-low reset
//   dl          download stream in / region write port out (slave modport)
//   ext_reset   user/menu reset request, active-high
//   core_reset  reset to the core, active-high
//   busy        high while loading or settling
//   load_ok     high once the core runs
//   load_err    high after a bad image
module rom_load_sequencer #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned R1_BASE     = 'h04000,
  parameter int unsigned R2_BASE     = 'h05000,
  parameter int unsigned R3_BASE     = 'h06000,
  parameter int unsigned END_ADDR    = 'h10000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  rom_load_sequencer_if.slave  dl,
  input  logic                 ext_reset,
  output logic                 core_reset,
  output logic                 busy,
  output logic                 load_ok,
  output logic                 load_err
);
  // One extra bit so END_ADDR, expected address and the saturated count all fit.
  localparam int unsigned CW  = ADDR_W + 1;
  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] R1_A    = ADDR_W'(R1_BASE);
  localparam logic [ADDR_W-1:0] R2_A    = ADDR_W'(R2_BASE);
  localparam logic [ADDR_W-1:0] R3_A    = ADDR_W'(R3_BASE);
  localparam logic [CW-1:0]     END_L   = CW'(END_ADDR);
  localparam logic [CW-1:0]     SAT_L   = CW'(END_ADDR + 1);
  localparam logic [HCW-1:0]    HOLD_LD = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {S_EMPTY, S_LOAD, S_HOLD, S_RUN, S_FAIL} state_t;

  state_t            state_q, state_d;
  logic              dl_active_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     exp_q, exp_d;
  logic              err_q, err_d;
  logic [HCW-1:0]    hold_q, hold_d;
  logic [3:0]        rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        rom_data_q, rom_data_d;
  logic              core_reset_q, core_reset_d;
  logic              busy_q, busy_d;
  logic              load_ok_q, load_ok_d;
  logic              load_err_q, load_err_d;

  logic [CW-1:0]     addr_x;
  logic              in_range, accept, oor, rise;
  logic [3:0]        region_we;
  logic [ADDR_W-1:0] region_base;

  assign addr_x   = {1'b0, dl.dl_addr};
  assign in_range = addr_x < END_L;
  assign accept   = dl.dl_active & dl.dl_wr & in_range;
  assign oor      = dl.dl_active & dl.dl_wr & ~in_range;
  assign rise     = dl.dl_active & ~dl_active_q;

  // State register: every flop of the block.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_EMPTY;
      dl_active_q  <= 1'b0;
      count_q      <= '0;
      exp_q        <= '0;
      err_q        <= 1'b0;
      hold_q       <= '0;
      rom_we_q     <= 4'b0000;
      rom_addr_q   <= '0;
      rom_data_q   <= 8'h00;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_active_q  <= dl.dl_active;
      count_q      <= count_d;
      exp_q        <= exp_d;
      err_q        <= err_d;
      hold_q       <= hold_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      load_ok_q    <= load_ok_d;
      load_err_q   <= load_err_d;
    end
  end

  // Write path and image tracking. A download start clears the tracking first so
  // a byte arriving on the start cycle is checked as the first byte of the image.
  always_comb begin
    region_we   = 4'b1000;
    region_base = R3_A;
    if (dl.dl_addr < R1_A) begin
      region_we   = 4'b0001;
      region_base = '0;
    end else if (dl.dl_addr < R2_A) begin
      region_we   = 4'b0010;
      region_base = R1_A;
    end else if (dl.dl_addr < R3_A) begin
      region_we   = 4'b0100;
      region_base = R2_A;
    end

    rom_we_d   = accept ? region_we : 4'b0000;
    rom_addr_d = accept ? (dl.dl_addr - region_base) : rom_addr_q;
    rom_data_d = accept ? dl.dl_data : rom_data_q;

    count_d = rise ? '0 : count_q;
    exp_d   = rise ? '0 : exp_q;
    err_d   = rise ? 1'b0 : err_q;
    if (accept) begin
      err_d = err_d | (addr_x != exp_d);
      exp_d = addr_x + CW'(1);
      if (count_d != SAT_L) begin
        count_d = count_d + CW'(1);
      end
    end
    if (oor) begin
      err_d = 1'b1;
    end
  end

  // Next-state logic; a download start wins from every state.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (rise) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (!dl.dl_active) begin
            if (count_q == END_L && !err_q) begin
              state_d = S_HOLD;
              hold_d  = HOLD_LD;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            state_d = S_RUN;
          end else begin
            hold_d = hold_q - HCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    core_reset_d = (state_d == S_RUN) ? ext_reset : 1'b1;
    busy_d       = (state_d == S_LOAD) || (state_d == S_HOLD);
    load_ok_d    = (state_d == S_RUN);
    load_err_d   = (state_d == S_FAIL);
  end

  assign dl.rom_we   = rom_we_q;
  assign dl.rom_addr = rom_addr_q;
  assign dl.rom_data = rom_data_q;
  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign load_ok     = load_ok_q;
  assign load_err    = load_err_q;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb/tb_rom_load_sequencer.sv - scoreboard bench for rom_load_sequencer
module tb_rom_load_sequencer;
  localparam int ADDR_W = 9;
  localparam int R1     = 'h040;
  localparam int R2     = 'h050;
  localparam int R3     = 'h060;
  localparam int END_A  = 'h100;
  localparam int HOLD   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ext_reset = 1'b0;
  logic core_reset, busy, load_ok, load_err;

  rom_load_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  rom_load_sequencer #(
    .ADDR_W(ADDR_W), .R1_BASE(R1), .R2_BASE(R2), .R3_BASE(R3),
    .END_ADDR(END_A), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys   (clk),
    .reset_n   (rst_n),
    .dl        (bus.slave),
    .ext_reset (ext_reset),
    .core_reset(core_reset),
    .busy      (busy),
    .load_ok   (load_ok),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [7:0]        last_data = 8'h00;
  int                acc[$];
  bit                oor_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: region decode and image verdict straight from the address map.
  function automatic logic [3:0] exp_we(int a);
    if (a < R1) return 4'b0001;
    if (a < R2) return 4'b0010;
    if (a < R3) return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic int exp_off(int a);
    if (a < R1) return a;
    if (a < R2) return a - R1;
    if (a < R3) return a - R2;
    return a - R3;
  endfunction

  function automatic bit model_ok();
    if (oor_seen) return 1'b0;
    if (acc.size() != END_A) return 1'b0;
    foreach (acc[i]) if (acc[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: every strobe must match the oldest expected write, on its cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_addr = '0;
      last_data = 8'h00;
    end else begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL strobe_missing addr=%0h expected_cycle=%0d now=%0d", sb[0].addr, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      checks++;
      if (bus.rom_we != 4'b0000) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected we=%b addr=%0h data=%0h expected=none", bus.rom_we, bus.rom_addr, bus.rom_data);
        end else begin
          mon_e = sb.pop_front();
          if (bus.rom_we !== mon_e.we || bus.rom_addr !== mon_e.addr ||
              bus.rom_data !== mon_e.data || cyc != mon_e.cyc) begin
            failures++;
            $display("FAIL strobe we=%b addr=%0h data=%0h cyc=%0d expected we=%b addr=%0h data=%0h cyc=%0d",
                     bus.rom_we, bus.rom_addr, bus.rom_data, cyc, mon_e.we, mon_e.addr, mon_e.data, mon_e.cyc);
          end
        end
        last_addr = bus.rom_addr;
        last_data = bus.rom_data;
      end else if (bus.rom_addr !== last_addr || bus.rom_data !== last_data) begin
        failures++;
        $display("FAIL rom_hold addr=%0h data=%0h expected addr=%0h data=%0h", bus.rom_addr, bus.rom_data, last_addr, last_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_status(string tag, logic cr, logic b, logic ok, logic er);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'(cr));
    chk({tag, "_busy"},       32'(busy),       32'(b));
    chk({tag, "_load_ok"},    32'(load_ok),    32'(ok));
    chk({tag, "_load_err"},   32'(load_err),   32'(er));
  endtask

  task automatic drive_byte(int a);
    logic [7:0] d;
    d = 8'($urandom);
    bus.dl_wr   = 1'b1;
    bus.dl_addr = ADDR_W'(a);
    bus.dl_data = d;
    if (bus.dl_active) begin
      if (a < END_A) begin
        sb.push_back('{we: exp_we(a), addr: ADDR_W'(exp_off(a)), data: d, cyc: cyc + 1});
        acc.push_back(a);
      end else begin
        oor_seen = 1'b1;
      end
    end
    step();
    bus.dl_wr = 1'b0;
    repeat ($urandom_range(0, 1)) step();
  endtask

  task automatic start_load();
    acc.delete();
    oor_seen = 1'b0;
    bus.dl_active = 1'b1;
  endtask

  task automatic end_load(string tag);
    bit ok;
    ok = model_ok();
    bus.dl_active = 1'b0;
    if (ok) begin
      repeat (HOLD) begin
        step();
        chk_status({tag, "_hold"}, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      step();
      chk_status({tag, "_run"}, 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      step();
      chk_status({tag, "_fail"}, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (4) step();
      chk_status({tag, "_fail_stay"}, 1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic run_stream(string tag, int skip, bit extra);
    start_load();
    for (int a = 0; a < END_A; a++) begin
      if (a != skip) drive_byte(a);
    end
    if (extra) drive_byte(END_A);
    end_load(tag);
  endtask

  initial begin
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = '0;
    bus.dl_data   = 8'h00;

    step();
    step();
    chk_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_rom_we",   32'(bus.rom_we),   32'h0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("reset_rom_data", 32'(bus.rom_data), 32'h0);
    rst_n = 1'b1;
    step();
    chk_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

    run_stream("good", -1, 1'b0);

    // ext_reset passes through one cycle late while running.
    chk("ext_pre", 32'(core_reset), 32'h0);
    ext_reset = 1'b1;
    chk("ext_delay", 32'(core_reset), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ext_high", 32'(core_reset), 32'h1);
    end
    ext_reset = 1'b0;
    step();
    chk("ext_low", 32'(core_reset), 32'h0);

    // Byte strobes outside a download are ignored.
    for (int i = 0; i < 6; i++) drive_byte($urandom_range(0, END_A - 1));
    step();
    chk_status("idle_wr", 1'b0, 1'b0, 1'b1, 1'b0);

    run_stream("skip", 'h23, 1'b0);
    run_stream("extra", -1, 1'b1);

    // Reset in the middle of a download.
    start_load();
    for (int a = 0; a < 100; a++) drive_byte(a);
    #2;
    rst_n = 1'b0;
    bus.dl_active = 1'b0;
    sb.delete();
    #1;
    chk_status("midreset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midreset_rom_we", 32'(bus.rom_we), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk_status("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // Good load, then a new download aborts the settle window.
    start_load();
    for (int a = 0; a < END_A; a++) drive_byte(a);
    bus.dl_active = 1'b0;
    repeat (5) step();
    chk_status("abort_hold", 1'b1, 1'b1, 1'b0, 1'b0);
    start_load();
    for (int a = 0; a < END_A; a++) begin
      drive_byte(a);
      if (a == 0) chk_status("abort_load", 1'b1, 1'b1, 1'b0, 1'b0);
      if (a == 40) chk_status("abort_still_load", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    end_load("reload");

    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
